fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch-stage PC register. Each cycle it drives the PC-source select and the fetch stall.
- Arbitrates between four sources, in priority order: execute-stage mispredict redirect, hazard-unit stall, instruction-memory wait, and the branch-predictor taken hint.
- Tracks fetches still outstanding when a redirect occurs and squashes their late responses.
- Keeps saturating counters of mispredicts and of fetch-stall cycles.

Parameters:
- CNT_W, 16, width of the mispredict and stall-cycle counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- stall_hazard_i  in  1  hazard unit requests a fetch hold (load-use and similar).
- pred_taken_f_i  in  1  predictor says the instruction at pc_f is a taken branch.
- mispredict_e_i  in  1  branch resolved in execute disagrees with the prediction.
- branch_taken_e_i  in  1  actual outcome of the resolving branch; valid only with mispredict_e_i.
- imem_ready_i  in  1  instruction memory returns the instruction for the outstanding request this cycle.
- imem_req_o  out  1  fetch request for the current pc_f.
- pc_src_o  out  2  PC mux select: 00 = pc+4, 01 = predicted target, 10 = pc_plus4_e, 11 = pc_target_e.
- stall_f_o  out  1  hold the PC register (drives its enable low).
- flush_d_o  out  1  invalidate the F/D pipeline register.
- flush_e_o  out  1  invalidate the D/E pipeline register.
- mispredict_cnt_o  out  CNT_W  saturating count of accepted redirects.
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_f_o = 1.

Behaviour:
- FSM states:
  - BOOT: first cycle after reset release. imem_req_o = 0, stall_f_o = 1, pc_src_o = 00. Moves to RUN unconditionally.
  - RUN: normal fetch. imem_req_o = 1.
  - SQUASH: a wrong-path response is still outstanding. imem_req_o = 0.
- Reset (reset_i = 0 sampled at an edge):
  - State becomes BOOT and both counters clear to 0.
  - While reset is asserted, outputs are pc_src_o = 00, stall_f_o = 1, flush_d_o = 1, flush_e_o = 1, imem_req_o = 0.
  - Reset mid-SQUASH abandons the squash; no response is dropped afterwards.
- redirect = mispredict_e_i in RUN or SQUASH. Redirect has the highest priority:
  - pc_src_o = branch_taken_e_i ? 11 : 10.
  - stall_f_o = 0, overriding hazard and memory stalls.
  - flush_d_o = 1 and flush_e_o = 1.
  - mispredict_cnt_o increments.
  - In RUN with imem_ready_i = 0, next state is SQUASH because the old fetch is still outstanding. In RUN with imem_ready_i = 1, next state is RUN.
  - Redirect while already in SQUASH stays in SQUASH. There is only one outstanding request, so only one drop is needed.
- RUN without redirect:
  - stall_f_o = stall_hazard_i | ~imem_ready_i.
  - When stall_f_o = 1, pc_src_o = 00.
  - When stall_f_o = 0, pc_src_o = pred_taken_f_i ? 01 : 00.
  - flush_d_o = ~imem_ready_i & ~stall_hazard_i, which inserts a bubble while memory waits. flush_e_o = 0.
- SQUASH without redirect:
  - stall_f_o = 1, pc_src_o = 00, flush_d_o = 1, flush_e_o = 0.
  - On imem_ready_i = 1 the wrong-path response is discarded and next state is RUN. Otherwise stay in SQUASH.
- Ignored inputs: pred_taken_f_i is ignored whenever stall_f_o = 1 or redirect. branch_taken_e_i is ignored without mispredict_e_i.
- stall_cnt_o increments in every non-reset cycle where stall_f_o = 1, including BOOT.
- Both counters saturate at 2^CNT_W-1 with no wrap.
- All outputs except the counters are combinational from state and inputs. Counter outputs are registered and update one cycle after the qualifying cycle.

Test Plan:
- Reset and boot: hold reset_i = 0 for 3 cycles, then release. Required:
  - Counters read 0 and flush_d_o = flush_e_o = 1 during reset.
  - The first cycle after release is BOOT: imem_req_o = 0, stall_f_o = 1.
  - The next cycle is RUN: imem_req_o = 1.
  - stall_cnt_o = 1 afterwards.
- Sequential and predicted fetch: imem_ready_i = 1, stall_hazard_i = 0. Apply pred_taken_f_i = 0 then 1. Required: pc_src_o = 00 then 01, and stall_f_o = 0 in both cycles.
- Memory wait: imem_ready_i = 0 for 3 cycles, with pred_taken_f_i = 1. Required:
  - stall_f_o = 1, pc_src_o = 00 and flush_d_o = 1 in each of those cycles.
  - stall_cnt_o grows by 3.
- Redirect priority: in one cycle set mispredict_e_i = 1, branch_taken_e_i = 1, stall_hazard_i = 1, imem_ready_i = 1. Required:
  - pc_src_o = 11, stall_f_o = 0, flush_d_o = flush_e_o = 1.
  - mispredict_cnt_o increments and the FSM stays in RUN.
  - Repeat with branch_taken_e_i = 0: pc_src_o = 10.
- Squash path: set mispredict_e_i = 1 with imem_ready_i = 0, then 2 idle cycles, then imem_ready_i = 1. Required:
  - SQUASH is entered with imem_req_o = 0.
  - stall_f_o = 1 and flush_d_o = 1 for all 3 SQUASH cycles, including the drop cycle.
  - RUN resumes the following cycle.
  - Also assert reset mid-SQUASH: the FSM goes to BOOT and no drop occurs.
- Saturation: set CNT_W = 4 and force 20 mispredicts. Required: mispredict_cnt_o holds at 15.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Purpose: fetch-stage PC sequencer; picks PC source, stalls/flushes front end, squashes wrong-path fetch.
// Latency: control outputs are combinational from state and inputs; counters update one cycle later.
// Backpressure: imem_ready_i low stalls PC (or holds SQUASH); redirect overrides hazard and memory stalls.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-low reset
//   stall_hazard_i       hazard unit requests a fetch hold
//   pred_taken_f_i       predictor taken hint for pc_f
//   mispredict_e_i       execute-stage branch mispredict
//   branch_taken_e_i     resolved branch outcome (valid with mispredict_e_i)
//   imem_ready_i         instruction memory response for the outstanding request
//   imem_req_o           fetch request for pc_f
//   pc_src_o             00 pc+4, 01 predicted target, 10 pc_plus4_e, 11 pc_target_e
//   stall_f_o            hold PC register
//   flush_d_o, flush_e_o invalidate F/D and D/E pipeline registers
//   mispredict_cnt_o     saturating count of accepted redirects
//   stall_cnt_o          saturating count of stalled fetch cycles
module fetch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_hazard_i,
    input  logic             pred_taken_f_i,
    input  logic             mispredict_e_i,
    input  logic             branch_taken_e_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [1:0]       pc_src_o,
    output logic             stall_f_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [CNT_W-1:0] mispredict_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        SQUASH = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   redirect;

    // A redirect is only honoured once fetching has started; BOOT ignores it.
    assign redirect = reset_i && mispredict_e_i && ((state == RUN) || (state == SQUASH));

    always_comb begin
        imem_req_o = 1'b0;
        pc_src_o   = 2'b00;
        stall_f_o  = 1'b1;
        flush_d_o  = 1'b1;
        flush_e_o  = 1'b0;
        state_nxt  = state;

        if (!reset_i) begin
            // Hold the whole front end quiet while reset is asserted.
            flush_e_o = 1'b1;
            state_nxt = BOOT;
        end else if (redirect) begin
            pc_src_o   = branch_taken_e_i ? 2'b11 : 2'b10;
            stall_f_o  = 1'b0;
            flush_e_o  = 1'b1;
            imem_req_o = (state == RUN);
            // The in-flight fetch belongs to the wrong path; if it has not
            // returned yet it must be dropped when it does. Only one request
            // can be outstanding, so a redirect inside SQUASH changes nothing.
            if (state == RUN && !imem_ready_i) begin
                state_nxt = SQUASH;
            end
        end else begin
            case (state)
                BOOT: begin
                    state_nxt = RUN;
                end
                RUN: begin
                    imem_req_o = 1'b1;
                    stall_f_o  = stall_hazard_i | ~imem_ready_i;
                    pc_src_o   = (!stall_f_o && pred_taken_f_i) ? 2'b01 : 2'b00;
                    // Bubble into decode only for a pure memory wait; a hazard
                    // hold must keep the F/D contents in place.
                    flush_d_o  = ~imem_ready_i & ~stall_hazard_i;
                end
                SQUASH: begin
                    // The response arriving now is the wrong-path one: drop it.
                    if (imem_ready_i) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state            <= BOOT;
            mispredict_cnt_o <= '0;
            stall_cnt_o      <= '0;
        end else begin
            state <= state_nxt;
            if (redirect && (mispredict_cnt_o != '1)) begin
                mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
            end
            if (stall_f_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl against a cycle-level reference model.
// Latency: checks control outputs mid-cycle and counters just after each rising edge.
// Backpressure: imem_ready_i and stall_hazard_i are driven directed and random to exercise stalls.
module tb_fetch_ctrl;

    logic clk_i = 1'b0;
    logic reset_i, stall_hazard_i, pred_taken_f_i, mispredict_e_i, branch_taken_e_i, imem_ready_i;

    logic        imem_req_o, stall_f_o, flush_d_o, flush_e_o;
    logic [1:0]  pc_src_o;
    logic [15:0] mispredict_cnt_o, stall_cnt_o;

    logic        s_imem_req, s_stall_f, s_flush_d, s_flush_e;
    logic [1:0]  s_pc_src;
    logic [3:0]  s_mis_cnt, s_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: front-end condition plus unbounded event counts.
    bit m_known = 0;
    bit m_booting = 0;
    bit m_wrong_path_pending = 0;
    int m_redirects = 0;
    int m_stalls = 0;

    always #5 clk_i = ~clk_i;

    fetch_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_hazard_i(stall_hazard_i),
        .pred_taken_f_i(pred_taken_f_i), .mispredict_e_i(mispredict_e_i),
        .branch_taken_e_i(branch_taken_e_i), .imem_ready_i(imem_ready_i),
        .imem_req_o(imem_req_o), .pc_src_o(pc_src_o), .stall_f_o(stall_f_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .mispredict_cnt_o(mispredict_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    fetch_ctrl #(.CNT_W(4)) dut_s (
        .clk_i(clk_i), .reset_i(reset_i), .stall_hazard_i(stall_hazard_i),
        .pred_taken_f_i(pred_taken_f_i), .mispredict_e_i(mispredict_e_i),
        .branch_taken_e_i(branch_taken_e_i), .imem_ready_i(imem_ready_i),
        .imem_req_o(s_imem_req), .pc_src_o(s_pc_src), .stall_f_o(s_stall_f),
        .flush_d_o(s_flush_d), .flush_e_o(s_flush_e),
        .mispredict_cnt_o(s_mis_cnt), .stall_cnt_o(s_stall_cnt)
    );

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    int cyc = 0;

    // One clock cycle: apply inputs, check combinational outputs, advance model, check counters.
    task automatic step(input bit rst_n, input bit haz, input bit pt, input bit mis, input bit bt, input bit rdy);
        bit e_req, e_stall, e_fd, e_fe, redir;
        logic [1:0] e_src;
        reset_i = rst_n; stall_hazard_i = haz; pred_taken_f_i = pt;
        mispredict_e_i = mis; branch_taken_e_i = bt; imem_ready_i = rdy;
        #1;
        redir = rst_n && mis && !m_booting && m_known;
        if (!rst_n) begin
            e_req = 0; e_stall = 1; e_src = 2'b00; e_fd = 1; e_fe = 1;
        end else if (m_booting) begin
            e_req = 0; e_stall = 1; e_src = 2'b00; e_fd = 1; e_fe = 0;
        end else if (redir) begin
            e_req = !m_wrong_path_pending; e_stall = 0;
            e_src = bt ? 2'b11 : 2'b10; e_fd = 1; e_fe = 1;
        end else if (m_wrong_path_pending) begin
            e_req = 0; e_stall = 1; e_src = 2'b00; e_fd = 1; e_fe = 0;
        end else begin
            e_req = 1; e_stall = haz || !rdy;
            e_src = (!e_stall && pt) ? 2'b01 : 2'b00;
            e_fd = !rdy && !haz; e_fe = 0;
        end
        chk("imem_req", cyc, 32'(imem_req_o), 32'(e_req));
        chk("stall_f", cyc, 32'(stall_f_o), 32'(e_stall));
        chk("pc_src", cyc, 32'(pc_src_o), 32'(e_src));
        chk("flush_d", cyc, 32'(flush_d_o), 32'(e_fd));
        chk("flush_e", cyc, 32'(flush_e_o), 32'(e_fe));
        chk("s_ctrl", cyc, {27'd0, s_imem_req, s_stall_f, s_pc_src, s_flush_d, s_flush_e},
            {27'd0, e_req, e_stall, e_src, e_fd, e_fe});
        @(posedge clk_i);
        #1;
        if (!rst_n) begin
            m_known = 1; m_booting = 1; m_wrong_path_pending = 0;
            m_redirects = 0; m_stalls = 0;
        end else if (m_known) begin
            if (e_stall) m_stalls++;
            if (redir) m_redirects++;
            if (m_booting) m_booting = 0;
            else if (redir) m_wrong_path_pending = m_wrong_path_pending || !rdy;
            else if (m_wrong_path_pending && rdy) m_wrong_path_pending = 0;
        end
        if (m_known) begin
            chk("mispredict_cnt", cyc, 32'(mispredict_cnt_o), 32'(sat(m_redirects, 16)));
            chk("stall_cnt", cyc, 32'(stall_cnt_o), 32'(sat(m_stalls, 16)));
            chk("s_mispredict_cnt", cyc, 32'(s_mis_cnt), 32'(sat(m_redirects, 4)));
            chk("s_stall_cnt", cyc, 32'(s_stall_cnt), 32'(sat(m_stalls, 4)));
        end
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        // Reset for 3 cycles, then BOOT and RUN.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        chk("reset_cnt", cyc, 32'(stall_cnt_o), 32'd0);
        step(1, 0, 0, 0, 0, 1);   // BOOT
        chk("boot_stall_cnt", cyc, 32'(stall_cnt_o), 32'd1);
        step(1, 0, 0, 0, 0, 1);   // RUN, sequential
        step(1, 0, 1, 0, 0, 1);   // RUN, predicted taken
        // Memory wait with taken hint ignored.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        chk("wait_stall_cnt", cyc, 32'(stall_cnt_o), 32'd4);
        // Redirect beats hazard stall; taken then not taken.
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 0, 1, 0, 1);
        chk("redir_cnt", cyc, 32'(mispredict_cnt_o), 32'd2);
        step(1, 0, 0, 0, 0, 1);   // still RUN
        // Squash path: redirect with memory busy, 2 idle, then drop.
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1);   // drop cycle
        step(1, 0, 1, 0, 0, 1);   // RUN resumes
        // Redirect inside SQUASH, then reset mid-SQUASH.
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);   // BOOT
        step(1, 0, 1, 0, 0, 1);   // RUN, no drop pending
        // Saturation of the narrow instance.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, i[0], 1);
        chk("sat_mispredict", cyc, 32'(s_mis_cnt), 32'd15);
        chk("wide_mispredict", cyc, 32'(mispredict_cnt_o), 32'd20);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
